dac_ramp_sequencer: RTL and testbench
=====================================

Name: dac_ramp_sequencer

Overview:
Command-driven setpoint controller for the delta-sigma DAC modulator. It accepts target codes over a valid/ready handshake and slews its registered code output toward each target, moving a bounded step at a programmable tick rate. Its output drives the modulator's DAC_in directly, giving glitch-free, slew-limited analog transitions. Status outputs report ramp progress to a host or register block.

Parameters:
WIDTH, 10, code width; must equal the modulator WIDTH.
RATE_W, 16, width of the tick-interval field.
RESET_CODE, 0, dac_code value after reset.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command
cmd_target  input  WIDTH  unsigned target code
cmd_step  input  WIDTH  max code change per tick; 0 is treated as 1
cmd_rate  input  RATE_W  tick interval; one tick every cmd_rate+1 clocks
abort  input  1  stop ramp, hold current code
dac_code  output  WIDTH  registered code to the modulator DAC_in
busy  output  1  ramp in progress
done  output  1  one-cycle pulse when target is reached

Behaviour:
- Reset (async assert, sync deassert at the top level): state=IDLE, dac_code=RESET_CODE, busy=0, done=0, prescaler=0, cmd_ready=1 after release.
- States: IDLE, RAMP, DONE.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid&cmd_ready at a clock edge: latch target, step (0→1) and rate.
  - Clear prescaler, go to RAMP, set busy=1 on the same edge.
- RAMP:
  - cmd_ready=0; commands are not accepted and are not queued.
  - Prescaler increments each clock. A tick occurs in the cycle where prescaler==rate latched; the prescaler then returns to 0.
  - With rate=0, a tick occurs every clock.
  - On tick, diff=|target−dac_code|, computed at WIDTH+1 bits with no wrap.
    - If diff<=step: dac_code=target; go to DONE.
    - Else: dac_code ±= step toward target. The result never overshoots or wraps past 0 or 2^WIDTH−1.
  - dac_code changes only on a tick edge.
  - Target equal to current code: the first tick completes with no code change.
  - The first tick occurs rate+1 clocks after the accept edge.
- DONE:
  - done=1 for exactly one cycle; busy=0; cmd_ready=0.
  - Next state is IDLE.
- abort:
  - In RAMP, abort forces IDLE at the next edge. dac_code holds its current value, busy=0, and no done pulse is issued.
  - abort has priority over a tick in the same cycle, so the code is not updated.
  - abort in IDLE or DONE is ignored; a DONE pulse already in progress still completes.
- cmd_valid and abort asserted in the same IDLE cycle: the command is accepted and abort is ignored.
- rst asserted mid-ramp: immediate return to the reset values above.
- All outputs are registered except cmd_ready, which is decoded from state.

Decomposition:
- Shared package dac_pkg:
  - state enum {IDLE, RAMP, DONE}.
  - Default WIDTH/RATE_W localparams, shared with the DAC modulator.
- One sub-module, dac_tick_prescaler:
  - Inputs: clk, rst, clear, rate[RATE_W].
  - Output: tick pulse.
  - Implements the counter and compare logic described above.
- Step/clamp arithmetic stays inline in the top module.

Test Plan:
- Reset with RESET_CODE=0 → dac_code=0, cmd_ready=1, busy=0. Accept target=100, step=10, rate=3 → code steps 10,20,…,100, one step every 4 clocks. First change 4 clocks after accept; done pulses once; busy drops.
- Code=100, target=7, step=30, rate=0 → dac_code sequence 70,40,10,7 on consecutive clocks, then done; no underflow.
- Target=1023, step=1000 from 100 → 1023 in one tick without wrap. cmd_step=0 from 5 to 8 → 6,7,8.
- abort asserted on the same cycle as a tick during ramp 0→500, step 50, at code=150 → code stays 150, no done, IDLE next cycle. Next command is accepted.
- cmd_valid held high during RAMP with a different target → not accepted (cmd_ready=0). It is accepted on the first IDLE cycle after done.
- Async rst asserted mid-ramp between clock edges → dac_code=RESET_CODE and busy=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC setpoint path: sequencer states and default
// widths that must stay in step with the delta-sigma modulator.
package dac_pkg;

  localparam int DEFAULT_WIDTH  = 10;
  localparam int DEFAULT_RATE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dac_ramp_sequencer_if.sv
// Command channel into the ramp sequencer: valid/ready handshake carrying the
// target, step and tick interval, plus the abort request.
interface dac_ramp_sequencer_if
  import dac_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int RATE_W = DEFAULT_RATE_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_target;
  logic [WIDTH-1:0]  cmd_step;
  logic [RATE_W-1:0] cmd_rate;
  logic              abort;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    output cmd_rate,
    output abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step,
    input  cmd_rate,
    input  abort,
    output cmd_ready
  );

endinterface

// File: rtl/dac_tick_prescaler.sv
// Free-running interval counter: tick is high in the cycle where the count
// equals rate, so ticks arrive every rate+1 clocks while clear is low.
module dac_tick_prescaler
  import dac_pkg::*;
#(
  parameter int RATE_W = DEFAULT_RATE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] count_reg;
  logic [RATE_W-1:0] count_next;

  assign tick = (count_reg == rate);

  always_comb begin
    count_next = count_reg + 1'b1;
    if (clear || tick) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/dac_ramp_sequencer.sv
// Slew-limited setpoint controller: accepts a target code and walks dac_code
// toward it by at most one step per prescaler tick, never overshooting.
module dac_ramp_sequencer
  import dac_pkg::*;
#(
  parameter int               WIDTH      = DEFAULT_WIDTH,
  parameter int               RATE_W     = DEFAULT_RATE_W,
  parameter logic [WIDTH-1:0] RESET_CODE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  dac_ramp_sequencer_if.slave  cmd,
  output logic [WIDTH-1:0]     dac_code,
  output logic                 busy,
  output logic                 done
);

  state_t            state_reg,  state_next;
  logic [WIDTH-1:0]  code_reg,   code_next;
  logic [WIDTH-1:0]  target_reg, target_next;
  logic [WIDTH-1:0]  step_reg,   step_next;
  logic [RATE_W-1:0] rate_reg,   rate_next;
  logic              busy_reg,   busy_next;
  logic              done_reg,   done_next;

  logic              tick;
  logic              ramp_up;
  logic [WIDTH:0]    diff;
  logic              within_step;
  logic [WIDTH-1:0]  stepped_code;

  // Counter runs only while ramping, so it restarts from 0 on every accept.
  dac_tick_prescaler #(
    .RATE_W (RATE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (state_reg != RAMP),
    .rate  (rate_reg),
    .tick  (tick)
  );

  assign cmd.cmd_ready = (state_reg == IDLE);
  assign dac_code      = code_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

  // Distance is taken one bit wider; a partial step is only taken when
  // diff > step, so code +/- step stays strictly inside [0, 2^WIDTH-1].
  always_comb begin
    ramp_up      = (target_reg >= code_reg);
    diff         = ramp_up ? ({1'b0, target_reg} - {1'b0, code_reg})
                           : ({1'b0, code_reg} - {1'b0, target_reg});
    within_step  = (diff <= {1'b0, step_reg});
    stepped_code = ramp_up ? (code_reg + step_reg) : (code_reg - step_reg);
  end

  always_comb begin
    state_next  = state_reg;
    code_next   = code_reg;
    target_next = target_reg;
    step_next   = step_reg;
    rate_next   = rate_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd.cmd_valid) begin
          target_next = cmd.cmd_target;
          step_next   = (cmd.cmd_step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1}
                                             : cmd.cmd_step;
          rate_next   = cmd.cmd_rate;
          busy_next   = 1'b1;
          state_next  = RAMP;
        end
      end
      RAMP: begin
        if (cmd.abort) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (tick) begin
          if (within_step) begin
            code_next  = target_reg;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            code_next = stepped_code;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      code_reg   <= RESET_CODE;
      target_reg <= RESET_CODE;
      step_reg   <= {{(WIDTH-1){1'b0}}, 1'b1};
      rate_reg   <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      code_reg   <= code_next;
      target_reg <= target_next;
      step_reg   <= step_next;
      rate_reg   <= rate_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// Directed scoreboard bench: each command pushes the expected code updates and
// done pulse (value and clock edge) which a negedge monitor pops and compares.
module tb_dac_ramp_sequencer;
  import dac_pkg::*;

  localparam int W  = 10;
  localparam int RW = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] dac_code;
  logic         busy;
  logic         done;

  dac_ramp_sequencer_if #(.WIDTH(W), .RATE_W(RW)) cmd_if ();

  dac_ramp_sequencer #(
    .WIDTH      (W),
    .RATE_W     (RW),
    .RESET_CODE ('0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int code;
    int cyc;
  } ev_t;

  ev_t          code_q[$];
  int           done_q[$];
  ev_t          mon_ev;
  int           mon_dcyc;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           model_code = 0;
  logic         mon_en = 1'b0;
  logic [W-1:0] prev_code = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every code change and every done cycle must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dac_code !== prev_code) begin
        checks++;
        assert (code_q.size() != 0) else begin
          errors++;
          $error("FAIL code_unexpected observed=%0d expected=none cyc=%0d", dac_code, cyc);
        end
        if (code_q.size() != 0) begin
          mon_ev = code_q.pop_front();
          checks++;
          assert (dac_code === 10'(mon_ev.code)) else begin
            errors++;
            $error("FAIL code_value observed=%0d expected=%0d", dac_code, mon_ev.code);
          end
          checks++;
          assert (cyc == mon_ev.cyc) else begin
            errors++;
            $error("FAIL code_time observed=%0d expected=%0d (code %0d)", cyc, mon_ev.cyc, mon_ev.code);
          end
        end
        prev_code = dac_code;
      end
      if (done === 1'b1) begin
        checks++;
        assert (done_q.size() != 0) else begin
          errors++;
          $error("FAIL done_unexpected observed=1 expected=0 cyc=%0d", cyc);
        end
        if (done_q.size() != 0) begin
          mon_dcyc = done_q.pop_front();
          checks++;
          assert (cyc == mon_dcyc) else begin
            errors++;
            $error("FAIL done_time observed=%0d expected=%0d", cyc, mon_dcyc);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference ramp: pushes each tick's new code (only when it changes) and the
  // done edge; limit >= 0 stops after that many code updates with no done.
  task automatic plan(input int tgt, input int stp, input int rate, input int acc, input int limit);
    int   cur = model_code;
    int   s   = (stp == 0) ? 1 : stp;
    int   e   = acc;
    int   n   = 0;
    int   d;
    ev_t  ev;
    while (1) begin
      e += rate + 1;
      if (limit >= 0 && n >= limit) break;
      d = (tgt > cur) ? tgt - cur : cur - tgt;
      if (d <= s) begin
        if (tgt != cur) begin
          ev.code = tgt; ev.cyc = e; code_q.push_back(ev);
        end
        cur = tgt;
        done_q.push_back(e);
        break;
      end
      cur = (tgt > cur) ? cur + s : cur - s;
      ev.code = cur; ev.cyc = e; code_q.push_back(ev);
      n++;
    end
    model_code = cur;
  endtask

  task automatic issue(input int tgt, input int stp, input int rate, input logic ab,
                       input int limit, output int acc);
    @(posedge clk); #1;
    check("ready_before_cmd", int'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 10'(tgt);
    cmd_if.cmd_step   = 10'(stp);
    cmd_if.cmd_rate   = 16'(rate);
    cmd_if.abort      = ab;
    acc = cyc + 1;
    plan(tgt, stp, rate, acc, limit);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.abort     = 1'b0;
    $display("cmd target=%0d step=%0d rate=%0d abort=%0d accepted at edge %0d", tgt, stp, rate, ab, acc);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (code_q.size() == 0 && done_q.size() == 0) break;
    end
    check({tag, "_drained"}, code_q.size() + done_q.size(), 0);
  endtask

  task automatic wait_idle(input string tag);
    wait_drain(tag);
    @(negedge clk);
    check({tag, "_ready"}, int'(cmd_if.cmd_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_code"}, int'(dac_code), model_code);
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = '0;
    cmd_if.cmd_step   = '0;
    cmd_if.cmd_rate   = '0;
    cmd_if.abort      = 1'b0;

    #12;
    check("reset_code", int'(dac_code), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("reset_ready", int'(cmd_if.cmd_ready), 1);
    mon_en = 1'b1;

    // 0 -> 100 in steps of 10, one tick every 4 clocks
    issue(100, 10, 3, 1'b0, -1, acc);
    @(negedge clk);
    check("ramp_busy", int'(busy), 1);
    check("ramp_ready", int'(cmd_if.cmd_ready), 0);
    wait_idle("up100");

    // 100 -> 7 downward, clamps at target without underflow
    issue(7, 30, 0, 1'b0, -1, acc);
    wait_idle("down7");

    issue(100, 255, 0, 1'b0, -1, acc);
    wait_idle("to100");
    issue(1023, 1000, 0, 1'b0, -1, acc);
    wait_idle("top1023");
    issue(5, 1023, 0, 1'b0, -1, acc);
    wait_idle("to5");
    issue(8, 0, 1, 1'b0, -1, acc);
    wait_idle("step0");

    // Target equal to current code: done only, no code change
    issue(8, 3, 2, 1'b0, -1, acc);
    wait_idle("same");

    // Abort coinciding with the 4th tick of 0 -> 500 step 50 rate 1
    issue(0, 1023, 0, 1'b0, -1, acc);
    wait_idle("to0");
    issue(500, 50, 1, 1'b0, 3, acc);
    while (cyc < acc + 7) begin @(posedge clk); #1; end
    cmd_if.abort = 1'b1;
    @(posedge clk); #1;
    cmd_if.abort = 1'b0;
    @(negedge clk);
    check("abort_code", int'(dac_code), 150);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_idle", int'(cmd_if.cmd_ready), 1);
    check("abort_queue", code_q.size() + done_q.size(), 0);
    issue(200, 50, 0, 1'b0, -1, acc);
    wait_idle("after_abort");

    // cmd_valid held through RAMP with new fields: accepted only after DONE
    @(posedge clk); #1;
    check("hold_ready", int'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 10'd300;
    cmd_if.cmd_step   = 10'd100;
    cmd_if.cmd_rate   = 16'd1;
    acc = cyc + 1;
    plan(300, 100, 1, acc, -1);
    plan(250, 25, 0, acc + 4, -1);
    @(posedge clk); #1;
    cmd_if.cmd_target = 10'd250;
    cmd_if.cmd_step   = 10'd25;
    cmd_if.cmd_rate   = 16'd0;
    @(negedge clk);
    check("hold_ready_ramp", int'(cmd_if.cmd_ready), 0);
    while (cyc < acc + 4) begin @(posedge clk); #1; end
    cmd_if.cmd_valid = 1'b0;
    $display("cmd target=300 then held target=250, second accept expected at edge %0d", acc + 4);
    wait_idle("held");

    // Abort together with a command in IDLE: command wins
    issue(260, 20, 0, 1'b1, -1, acc);
    wait_idle("abort_idle_cmd");

    // Asynchronous reset between clock edges in the middle of a ramp
    issue(900, 10, 2, 1'b0, 2, acc);
    wait_drain("pre_rst");
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_code", int'(dac_code), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    code_q.delete();
    done_q.delete();
    @(negedge clk); rst = 1'b0;
    prev_code = '0;
    model_code = 0;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(cmd_if.cmd_ready), 1);
    issue(3, 1, 0, 1'b0, -1, acc);
    wait_idle("post_rst");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
